valu_opreq: RTL and testbench

VALU_OPREQ -- requirements
Module: valu_opreq

---
 rtl/valu_opreq.sv | 130 +++++++++++++
 tb/tb_valu_opreq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/valu_opreq.sv
// Vector ALU operand-request sequencer: fetches vs1/vs2 words from the VRF and streams them
// into two credit-managed ALU operand buffers, then reports completion of the request.
module valu_opreq #(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned AddrWidth  = 8,
  parameter int unsigned VlWidth    = 16,
  parameter int unsigned OpBufDepth = 4,
  parameter int unsigned IdWidth    = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [1:0][AddrWidth-1:0]      req_vs_addr_i,
  input  logic [1:0]                     req_use_vs_i,
  input  logic [VlWidth-1:0]             req_vlB_i,
  input  logic [IdWidth-1:0]             req_id_i,
  output logic [1:0]                     rd_req_o,
  output logic [1:0][AddrWidth-1:0]      rd_addr_o,
  input  logic [1:0]                     rd_gnt_i,
  input  logic [1:0][DataWidth-1:0]      rd_data_i,
  output logic [1:0]                     op_valid_o,
  output logic [1:0][DataWidth-1:0]      op_data_o,
  input  logic [1:0]                     op_pop_i,
  output logic                           done_o,
  output logic [IdWidth-1:0]             done_id_o
);

  localparam int unsigned CredWidth = $clog2(OpBufDepth + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

  state_e                          state_q, state_d;
  logic [1:0][AddrWidth-1:0]       addr_q, addr_d;
  logic [1:0][VlWidth:0]           words_q, words_d;
  logic [1:0][CredWidth-1:0]       credit_q, credit_d;
  logic [1:0]                      pend_q, pend_d;
  logic [IdWidth-1:0]              id_q, id_d;

  logic                            accept;
  logic [1:0]                      gnt_ok;
  logic [VlWidth:0]                vl_round;
  logic [VlWidth:0]                words_calc;

  // One extra bit keeps the +7 round-up from overflowing at vlB = all-ones.
  assign vl_round   = {1'b0, req_vlB_i} + (VlWidth + 1)'(7);
  assign words_calc = vl_round >> 3;

  assign accept = req_valid_i & req_ready_o;
  assign gnt_ok = rd_gnt_i & rd_req_o;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DRAIN always lasts one cycle since returns arrive one cycle after grant.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StBusy;
      StBusy:  if (words_d[0] == '0 && words_d[1] == '0) state_d = StDrain;
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; everything is masked while reset is held so in-flight returns are dropped.
  always_comb begin
    req_ready_o = (state_q == StIdle) & ~rst_i;
    done_o      = (state_q == StDrain) & ~rst_i;
    done_id_o   = id_q;
    op_valid_o  = pend_q & {2{~rst_i}};
    op_data_o   = rd_data_i;
    rd_addr_o   = addr_q;
    for (int i = 0; i < 2; i++) begin
      rd_req_o[i] = ~rst_i & (state_q == StBusy) & (words_q[i] != '0) & (credit_q[i] != '0);
    end
  end

  // Per-port address, word count and credit bookkeeping.
  always_comb begin
    addr_d   = addr_q;
    words_d  = words_q;
    credit_d = credit_q;
    pend_d   = gnt_ok;
    id_d     = id_q;
    if (accept) begin
      id_d = req_id_i;
    end
    for (int i = 0; i < 2; i++) begin
      if (accept) begin
        addr_d[i]  = req_vs_addr_i[i];
        words_d[i] = req_use_vs_i[i] ? words_calc : '0;
      end
      if (gnt_ok[i]) begin
        addr_d[i]  = addr_q[i] + AddrWidth'(1);
        words_d[i] = words_q[i] - (VlWidth + 1)'(1);
      end
      // Grant and pop together cancel; a pop with a full credit pool is ignored.
      if (gnt_ok[i] && !op_pop_i[i]) begin
        credit_d[i] = credit_q[i] - CredWidth'(1);
      end else if (!gnt_ok[i] && op_pop_i[i] && credit_q[i] < CredWidth'(OpBufDepth)) begin
        credit_d[i] = credit_q[i] + CredWidth'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      words_q  <= '0;
      credit_q <= {2{CredWidth'(OpBufDepth)}};
      pend_q   <= '0;
      id_q     <= '0;
    end else begin
      addr_q   <= addr_d;
      words_q  <= words_d;
      credit_q <= credit_d;
      pend_q   <= pend_d;
      id_q     <= id_d;
    end
  end

endmodule

// File: tb/tb_valu_opreq.sv
// Bench for valu_opreq: directed scenarios plus randomized requests, grants and pops,
// checked every cycle against a transaction-level model of the request.
module tb_valu_opreq;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 8;
  localparam int unsigned VW = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IW = 4;

  logic                 clk;
  logic                 rst;
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0][AW-1:0]   req_vs_addr;
  logic [1:0]           req_use_vs;
  logic [VW-1:0]        req_vlb;
  logic [IW-1:0]        req_id;
  logic [1:0]           rd_req;
  logic [1:0][AW-1:0]   rd_addr;
  logic [1:0]           rd_gnt;
  logic [1:0][DW-1:0]   rd_data;
  logic [1:0]           op_valid;
  logic [1:0][DW-1:0]   op_data;
  logic [1:0]           op_pop;
  logic                 done;
  logic [IW-1:0]        done_id;

  valu_opreq #(
    .DataWidth (DW),
    .AddrWidth (AW),
    .VlWidth   (VW),
    .OpBufDepth(DEPTH),
    .IdWidth   (IW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_vs_addr_i(req_vs_addr),
    .req_use_vs_i (req_use_vs),
    .req_vlB_i    (req_vlb),
    .req_id_i     (req_id),
    .rd_req_o     (rd_req),
    .rd_addr_o    (rd_addr),
    .rd_gnt_i     (rd_gnt),
    .rd_data_i    (rd_data),
    .op_valid_o   (op_valid),
    .op_data_o    (op_data),
    .op_pop_i     (op_pop),
    .done_o       (done),
    .done_id_o    (done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Model: request phase (0 idle, 1 fetching, 2 finishing), words per port, words issued,
  // words granted but not yet popped (credit = DEPTH - out), words sitting in the buffer.
  int              m_phase;
  logic [AW-1:0]   m_base[2];
  int              m_total[2];
  int              m_issued[2];
  int              m_out[2];
  int              m_occ[2];
  logic            m_push_due[2];
  logic [DW-1:0]   m_push_data[2];
  logic [IW-1:0]   m_id;

  int              gnt_mode;
  int              pop_mode;
  logic            pop_force[2];
  int              obs_grants[2];
  int              obs_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs at negedge, advance model at posedge.
  task automatic tick();
    logic          e_req[2];
    logic [AW-1:0] e_addr[2];
    logic          hon;
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = m_push_due[p] ? m_push_data[p] : {$urandom, $urandom};
      case (gnt_mode)
        0:       rd_gnt[p] = 1'b0;
        1:       rd_gnt[p] = 1'b1;
        default: rd_gnt[p] = 1'($urandom_range(0, 1));
      endcase
      op_pop[p] = pop_force[p] || (pop_mode == 1 && m_occ[p] > 0) ||
                  (pop_mode == 2 && m_occ[p] > 0 && $urandom_range(0, 2) == 0);
      pop_force[p] = 1'b0;
    end
    @(negedge clk);
    check("req_ready", 64'(req_ready), 64'(!rst && m_phase == 0));
    for (int p = 0; p < 2; p++) begin
      e_req[p]  = !rst && m_phase == 1 && m_issued[p] < m_total[p] && m_out[p] < DEPTH;
      e_addr[p] = AW'(m_base[p] + AW'(m_issued[p]));
      check($sformatf("rd_req%0d", p), 64'(rd_req[p]), 64'(e_req[p]));
      if (e_req[p]) check($sformatf("rd_addr%0d", p), 64'(rd_addr[p]), 64'(e_addr[p]));
      check($sformatf("op_valid%0d", p), 64'(op_valid[p]), 64'(!rst && m_push_due[p]));
      if (!rst && m_push_due[p]) check($sformatf("op_data%0d", p), op_data[p], m_push_data[p]);
      if (rd_req[p] && rd_gnt[p]) obs_grants[p]++;
    end
    check("done", 64'(done), 64'(!rst && m_phase == 2));
    if (!rst && m_phase == 2) check("done_id", 64'(done_id), 64'(m_id));
    if (done) obs_done++;
    @(posedge clk);
    if (rst) begin
      m_phase = 0;
      for (int p = 0; p < 2; p++) begin
        m_total[p] = 0; m_issued[p] = 0; m_out[p] = 0; m_occ[p] = 0; m_push_due[p] = 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        hon = e_req[p] && rd_gnt[p];
        if (m_push_due[p]) m_occ[p]++;
        if (op_pop[p] && m_occ[p] > 0) m_occ[p]--;
        m_out[p] = m_out[p] + int'(hon) - int'(op_pop[p]);
        if (m_out[p] < 0) m_out[p] = 0;
        m_issued[p]    += int'(hon);
        m_push_due[p]  = hon;
        m_push_data[p] = {$urandom, $urandom};
      end
      case (m_phase)
        0: if (req_valid) begin
          m_phase = 1;
          m_id    = req_id;
          for (int p = 0; p < 2; p++) begin
            m_base[p]   = req_vs_addr[p];
            m_total[p]  = req_use_vs[p] ? (int'(req_vlb) + 7) / 8 : 0;
            m_issued[p] = 0;
          end
        end
        1: if (m_issued[0] == m_total[0] && m_issued[1] == m_total[1]) m_phase = 2;
        default: m_phase = 0;
      endcase
    end
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [1:0] use_vs, input logic [VW-1:0] vlb,
                       input logic [IW-1:0] id);
    req_vs_addr[0] = a0;
    req_vs_addr[1] = a1;
    req_use_vs     = use_vs;
    req_vlb        = vlb;
    req_id         = id;
    obs_grants[0]  = 0;
    obs_grants[1]  = 0;
    obs_done       = 0;
    req_valid      = 1'b1;
    tick();
    req_valid      = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (m_phase != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("request_finished", 64'(m_phase == 0 && obs_done == 1), 64'(1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    m_phase = 0; m_id = '0;
    for (int p = 0; p < 2; p++) begin
      m_base[p] = '0; m_total[p] = 0; m_issued[p] = 0; m_out[p] = 0; m_occ[p] = 0;
      m_push_due[p] = 1'b0; m_push_data[p] = '0; pop_force[p] = 1'b0; obs_grants[p] = 0;
    end
    obs_done = 0;
    rst = 1'b1; req_valid = 1'b0; req_vs_addr = '0; req_use_vs = '0; req_vlb = '0;
    req_id = '0; rd_gnt = '0; rd_data = '0; op_pop = '0;
    gnt_mode = 0; pop_mode = 0;
    @(posedge clk); #1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Basic two-port fetch, 3 words each.
    gnt_mode = 1; pop_mode = 1;
    issue(8'h10, 8'h20, 2'b11, 16'd24, 4'h1);
    wait_idle(50);
    check("basic_p0_reads", 64'(obs_grants[0]), 64'(3));
    check("basic_p1_reads", 64'(obs_grants[1]), 64'(3));

    // Round-up and empty requests.
    issue(8'h33, 8'h44, 2'b11, 16'd9, 4'h2);
    wait_idle(50);
    check("vl9_p0_reads", 64'(obs_grants[0]), 64'(2));
    check("vl9_p1_reads", 64'(obs_grants[1]), 64'(2));
    issue(8'h33, 8'h44, 2'b11, 16'd0, 4'h3);
    wait_idle(10);
    check("vl0_reads", 64'(obs_grants[0] + obs_grants[1]), 64'(0));
    issue(8'h33, 8'h44, 2'b00, 16'd40, 4'h4);
    wait_idle(10);
    check("nouse_reads", 64'(obs_grants[0] + obs_grants[1]), 64'(0));

    // Address wrap.
    issue(8'hFF, 8'h00, 2'b01, 16'd16, 4'h5);
    wait_idle(50);
    check("wrap_p0_reads", 64'(obs_grants[0]), 64'(2));

    // Credit exhaustion on port 1 only, then a single pop.
    repeat (6) tick();
    pop_mode = 0;
    issue(8'h00, 8'h50, 2'b10, 16'd64, 4'h6);
    repeat (12) tick();
    check("stall_p1_reads", 64'(obs_grants[1]), 64'(4));
    check("stall_p0_reads", 64'(obs_grants[0]), 64'(0));
    pop_force[1] = 1'b1;
    repeat (5) tick();
    check("one_pop_p1_reads", 64'(obs_grants[1]), 64'(5));
    pop_mode = 1;
    wait_idle(100);
    check("stall_p1_total", 64'(obs_grants[1]), 64'(8));

    // Grant and pop together at credit 1.
    repeat (6) tick();
    pop_mode = 0;
    issue(8'h60, 8'h00, 2'b01, 16'd48, 4'h7);
    repeat (3) tick();
    pop_force[0] = 1'b1;
    tick();
    tick();
    check("gnt_pop_reads", 64'(obs_grants[0]), 64'(5));
    tick();
    check("gnt_pop_stall", 64'(obs_grants[0]), 64'(5));
    pop_mode = 1;
    wait_idle(100);

    // Reset the cycle after a grant; credits must come back full.
    issue(8'h70, 8'h80, 2'b11, 16'd40, 4'h8);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    pop_mode = 0;
    issue(8'h30, 8'h40, 2'b11, 16'd64, 4'h9);
    repeat (10) tick();
    check("post_rst_p0_reads", 64'(obs_grants[0]), 64'(4));
    check("post_rst_p1_reads", 64'(obs_grants[1]), 64'(4));
    pop_mode = 1;
    wait_idle(100);

    // req_valid held high throughout: only accepted when idle.
    req_vs_addr[0] = 8'hA0; req_vs_addr[1] = 8'hB0; req_use_vs = 2'b11;
    req_vlb = 16'd17; req_id = 4'hA;
    req_valid = 1'b1;
    repeat (30) tick();
    req_valid = 1'b0;
    obs_done = 0;
    if (m_phase != 0) wait_idle(50);

    // Maximum length: no overflow in the word count.
    repeat (6) tick();
    issue(8'h00, 8'h00, 2'b01, 16'hFFFF, 4'hB);
    wait_idle(10000);
    check("max_len_reads", 64'(obs_grants[0]), 64'(8192));

    // Random requests, grants and pops.
    for (int t = 0; t < 40; t++) begin
      gnt_mode = 2; pop_mode = 2;
      issue(AW'($urandom), AW'($urandom), 2'($urandom_range(0, 3)),
            VW'($urandom_range(0, 80)), IW'($urandom));
      wait_idle(3000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
